// File: rtl/out_port_arbiter_pkg.sv
// Shared definitions for the output-port arbiter: default sizes, flit layout
// helpers and the two-state FSM encoding.
package out_port_arbiter_pkg;

    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_IN_PORTS  = 5;

    // FSM encodings kept as plain constants so older code can compare raw bits
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Flit = {tail, addr, data}
    function automatic int flit_width(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    // The tail flag is the MSB of the flit
    function automatic int tail_index(input int data_size, input int addr_size);
        return data_size + addr_size;
    endfunction

    // Width of a port index; a single port still needs one bit to hold 0
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/out_port_arbiter_if.sv
// Handshake bundle between the input FIFOs, the arbiter and the downstream link.
// master = side that owns the FIFOs and the downstream link, slave = arbiter.
interface out_port_arbiter_if
    import out_port_arbiter_pkg::*;
#(
    parameter int IN_PORTS  = DEF_IN_PORTS,
    parameter int FLIT_SIZE = flit_width(DEF_DATA_SIZE, DEF_ADDR_SIZE)
);

    logic [IN_PORTS-1:0]           req_i;
    logic [IN_PORTS-1:0]           wr_ready_in;
    logic [IN_PORTS*FLIT_SIZE-1:0] data_i;
    logic [IN_PORTS-1:0]           r_ready_out;
    logic [FLIT_SIZE-1:0]          data_o;
    logic                          wr_ready_out;
    logic                          r_ready_in;
    logic [IN_PORTS-1:0]           grant_o;
    logic [31:0]                   pkt_cnt;

    modport master (
        output req_i, wr_ready_in, data_i, r_ready_in,
        input  r_ready_out, data_o, wr_ready_out, grant_o, pkt_cnt
    );

    modport slave (
        input  req_i, wr_ready_in, data_i, r_ready_in,
        output r_ready_out, data_o, wr_ready_out, grant_o, pkt_cnt
    );

endinterface

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after ptr,
// wrapping around. The candidate vector is doubled so the wrap becomes a
// plain lowest-set-bit search over the masked upper part.
module out_port_arbiter_rr_pick
    import out_port_arbiter_pkg::*;
#(
    parameter int IN_PORTS = DEF_IN_PORTS,
    parameter int PTR_W    = ptr_width(DEF_IN_PORTS)
) (
    input  logic [IN_PORTS-1:0] cand,
    input  logic [PTR_W-1:0]    ptr,
    output logic [IN_PORTS-1:0] onehot,
    output logic                any
);

    logic [2*IN_PORTS-1:0] dbl_masked;
    logic                  found;

    // Clear lower-copy bits below ptr so the search starts at ptr
    always_comb begin
        dbl_masked = {cand, cand};
        for (int i = 0; i < IN_PORTS; i++) begin
            if (i < int'(ptr)) begin
                dbl_masked[i] = 1'b0;
            end
        end
    end

    // Lowest set bit of the masked double vector, folded back to a port index
    always_comb begin
        onehot = '0;
        found  = 1'b0;
        for (int i = 0; i < 2*IN_PORTS; i++) begin
            if (dbl_masked[i] && !found) begin
                onehot[i % IN_PORTS] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign any = |cand;

endmodule

// File: rtl/out_port_arbiter.sv
// Wormhole round-robin arbiter for one switch output port. A winner keeps the
// output from head flit to tail flit; flits pass through a one-entry output
// register toward the downstream link. Also counts forwarded packets.
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int IN_PORTS  = DEF_IN_PORTS
) (
    input  logic             clk,
    input  logic             a_rst,
    out_port_arbiter_if.slave port_bus
);

    localparam int FLIT_SIZE = flit_width(DATA_SIZE, ADDR_SIZE);
    localparam int TAIL_BIT  = tail_index(DATA_SIZE, ADDR_SIZE);
    localparam int PTR_W     = ptr_width(IN_PORTS);

    logic [0:0]           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [PTR_W-1:0]     pick_idx;
    logic [PTR_W-1:0]     next_ptr;
    logic [IN_PORTS-1:0]  grant_r;
    logic [IN_PORTS-1:0]  cand;
    logic [IN_PORTS-1:0]  pick_onehot;
    logic                 pick_any;
    logic [FLIT_SIZE-1:0] owner_flit;
    logic [FLIT_SIZE-1:0] data_r;
    logic                 valid_r;
    logic [31:0]          pkt_cnt_r;
    logic                 owner_ready;
    logic                 owner_tail;
    logic                 accept;

    assign cand = port_bus.req_i & port_bus.wr_ready_in;

    out_port_arbiter_rr_pick #(
        .IN_PORTS (IN_PORTS),
        .PTR_W    (PTR_W)
    ) u_rr_pick (
        .cand   (cand),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .any    (pick_any)
    );

    // Convert the picker's one-hot result into the owner index
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Select the owner's FIFO-head flit and valid using the one-hot grant
    always_comb begin
        owner_flit  = '0;
        owner_ready = 1'b0;
        for (int i = 0; i < IN_PORTS; i++) begin
            if (grant_r[i]) begin
                owner_flit  = port_bus.data_i[i*FLIT_SIZE +: FLIT_SIZE];
                owner_ready = port_bus.wr_ready_in[i];
            end
        end
    end

    // A flit moves when the owner has one and the output register has room
    assign owner_tail = owner_flit[TAIL_BIT];
    assign accept     = (state == ST_LOCKED) && owner_ready && (!valid_r || port_bus.r_ready_in);
    assign next_ptr   = (owner == PTR_W'(IN_PORTS - 1)) ? '0 : owner + PTR_W'(1);

    // Arbitrate in IDLE, hold the grant in LOCKED until the tail is accepted
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            grant_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_r <= pick_onehot;
                        owner   <= pick_idx;
                        state   <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (accept && owner_tail) begin
                        grant_r <= '0;
                        rr_ptr  <= next_ptr;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-entry output register; drains and reloads in the same cycle
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (accept) begin
            data_r  <= owner_flit;
            valid_r <= 1'b1;
        end else if (port_bus.r_ready_in) begin
            valid_r <= 1'b0;
        end
    end

    // Count every accepted tail flit, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            pkt_cnt_r <= '0;
        end else if (accept && owner_tail) begin
            pkt_cnt_r <= pkt_cnt_r + 32'd1;
        end
    end

    assign port_bus.r_ready_out  = grant_r & {IN_PORTS{accept}};
    assign port_bus.data_o       = data_r;
    assign port_bus.wr_ready_out = valid_r;
    assign port_bus.grant_o      = grant_r;
    assign port_bus.pkt_cnt      = pkt_cnt_r;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: input FIFOs are queues popped on
// r_ready_out, the downstream side collects flits when valid meets ready,
// and expected grants/flits/counts are written out by hand per scenario.
module tb_out_port_arbiter;

    localparam int DS = 8;
    localparam int AS = 4;
    localparam int NP = 5;
    localparam int FS = DS + AS + 1;

    logic clk = 1'b0;
    logic a_rst;

    always #5 clk = ~clk;

    out_port_arbiter_if #(.IN_PORTS(NP), .FLIT_SIZE(FS)) bus ();

    out_port_arbiter #(
        .DATA_SIZE (DS),
        .ADDR_SIZE (AS),
        .IN_PORTS  (NP)
    ) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .port_bus (bus)
    );

    logic [FS-1:0] fifo [NP][$];
    logic [FS-1:0] rx [$];
    logic [FS-1:0] exp_q [$];
    logic [NP-1:0] stall;
    logic          rdy;
    logic [NP-1:0] s_pop;
    logic          s_drain;
    logic [FS-1:0] s_data;
    int            checks = 0;
    int            passes = 0;

    function automatic logic [FS-1:0] mk(input int p, input int s, input bit t);
        logic [3:0] pp;
        logic [3:0] ss;
        pp = 4'(p);
        ss = 4'(s);
        return {t, 4'hA, pp, ss};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, act, expv);
        end else begin
            passes++;
        end
    endtask

    // Drive FIFO heads, requests and the downstream ready onto the bus
    task automatic applyStimulus();
        for (int i = 0; i < NP; i++) begin
            bus.req_i[i]       = (fifo[i].size() > 0);
            bus.wr_ready_in[i] = (fifo[i].size() > 0) && !stall[i];
            bus.data_i[i*FS +: FS] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
        bus.r_ready_in = rdy;
    endtask

    // Re-drive inputs and capture the handshakes that the next edge will act on
    task automatic refresh();
        applyStimulus();
        #1;
        s_pop   = bus.r_ready_out;
        s_drain = bus.wr_ready_out & bus.r_ready_in;
        s_data  = bus.data_o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_drain) rx.push_back(s_data);
        for (int i = 0; i < NP; i++) begin
            if (s_pop[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
        refresh();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NP; i++) fifo[i].delete();
        rx.delete();
        exp_q.delete();
        stall   = '0;
        rdy     = 1'b1;
        s_pop   = '0;
        s_drain = 1'b0;
        s_data  = '0;
    endtask

    task automatic do_reset();
        a_rst = 1'b1;
        clear_all();
        refresh();
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        refresh();
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 200; n++) begin
            idle = (bus.grant_o == '0) && !bus.wr_ready_out;
            for (int i = 0; i < NP; i++) if (fifo[i].size() > 0) idle = 1'b0;
            if (idle) break;
            tick();
        end
        checkOutput("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        int n;
        checkOutput({tag, "_count"}, rx.size(), exp_q.size());
        n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++) checkOutput({tag, "_flit"}, 32'(rx[i]), 32'(exp_q[i]));
        rx.delete();
        exp_q.delete();
    endtask

    initial begin
        // ---- reset values
        a_rst = 1'b1;
        clear_all();
        refresh();
        tick();
        tick();
        checkOutput("rst_grant", 32'(bus.grant_o), 32'd0);
        checkOutput("rst_valid", 32'(bus.wr_ready_out), 32'd0);
        checkOutput("rst_data", 32'(bus.data_o), 32'd0);
        checkOutput("rst_pkt_cnt", bus.pkt_cnt, 32'd0);
        checkOutput("rst_rready", 32'(bus.r_ready_out), 32'd0);
        a_rst = 1'b0;
        refresh();

        // ---- 1: reset mid-packet, then rr_ptr must be back at 0
        $display("[TB] scenario 1: reset during a packet");
        fifo[3].push_back(mk(3, 0, 1));
        exp_q.push_back(mk(3, 0, 1));
        refresh();
        wait_idle();
        check_rx("s1_pre");
        checkOutput("s1_pre_cnt", bus.pkt_cnt, 32'd1);
        fifo[4].push_back(mk(4, 0, 0));
        fifo[4].push_back(mk(4, 1, 0));
        fifo[4].push_back(mk(4, 2, 1));
        refresh();
        tick();
        checkOutput("s1_grant4", 32'(bus.grant_o), 32'h10);
        tick();
        checkOutput("s1_head", 32'(bus.data_o), 32'(mk(4, 0, 0)));
        a_rst = 1'b1;
        #1;
        checkOutput("s1_rst_grant", 32'(bus.grant_o), 32'd0);
        checkOutput("s1_rst_valid", 32'(bus.wr_ready_out), 32'd0);
        checkOutput("s1_rst_cnt", bus.pkt_cnt, 32'd0);
        clear_all();
        fifo[4].push_back(mk(4, 5, 1));
        fifo[0].push_back(mk(0, 5, 1));
        exp_q.push_back(mk(0, 5, 1));
        exp_q.push_back(mk(4, 5, 1));
        applyStimulus();
        #1;
        a_rst = 1'b0;
        refresh();
        tick();
        checkOutput("s1_grant0", 32'(bus.grant_o), 32'h01);
        wait_idle();
        check_rx("s1");
        checkOutput("s1_cnt", bus.pkt_cnt, 32'd2);

        // ---- 2: inputs 1 and 3 contend from rr_ptr=0
        $display("[TB] scenario 2: round-robin between 1 and 3");
        do_reset();
        fifo[1].push_back(mk(1, 0, 0));
        fifo[1].push_back(mk(1, 1, 1));
        fifo[3].push_back(mk(3, 0, 0));
        fifo[3].push_back(mk(3, 1, 1));
        exp_q.push_back(mk(1, 0, 0));
        exp_q.push_back(mk(1, 1, 1));
        exp_q.push_back(mk(3, 0, 0));
        exp_q.push_back(mk(3, 1, 1));
        refresh();
        tick();
        checkOutput("s2_grant1", 32'(bus.grant_o), 32'h02);
        tick();
        tick();
        tick();
        checkOutput("s2_grant3", 32'(bus.grant_o), 32'h08);
        wait_idle();
        check_rx("s2");
        checkOutput("s2_cnt", bus.pkt_cnt, 32'd2);

        // ---- 3: no interleave when input 0 requests mid-packet
        $display("[TB] scenario 3: wormhole hold");
        for (int k = 0; k < 4; k++) begin
            fifo[2].push_back(mk(2, k, k == 3));
            exp_q.push_back(mk(2, k, k == 3));
        end
        exp_q.push_back(mk(0, 0, 1));
        refresh();
        tick();
        checkOutput("s3_grant2", 32'(bus.grant_o), 32'h04);
        tick();
        tick();
        fifo[0].push_back(mk(0, 0, 1));
        refresh();
        tick();
        checkOutput("s3_hold2", 32'(bus.grant_o), 32'h04);
        wait_idle();
        check_rx("s3");
        checkOutput("s3_cnt", bus.pkt_cnt, 32'd4);

        // ---- 4: downstream backpressure for 5 cycles
        $display("[TB] scenario 4: backpressure");
        for (int k = 0; k < 6; k++) begin
            fifo[1].push_back(mk(1, k, k == 5));
            exp_q.push_back(mk(1, k, k == 5));
        end
        refresh();
        tick();
        checkOutput("s4_grant1", 32'(bus.grant_o), 32'h02);
        tick();
        rdy = 1'b0;
        refresh();
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("s4_stall_data", 32'(bus.data_o), 32'(mk(1, 0, 0)));
            checkOutput("s4_stall_rready", 32'(bus.r_ready_out), 32'd0);
            checkOutput("s4_stall_valid", 32'(bus.wr_ready_out), 32'd1);
        end
        rdy = 1'b1;
        refresh();
        tick();
        checkOutput("s4_next1", 32'(bus.data_o), 32'(mk(1, 1, 0)));
        tick();
        checkOutput("s4_next2", 32'(bus.data_o), 32'(mk(1, 2, 0)));
        wait_idle();
        check_rx("s4");
        checkOutput("s4_cnt", bus.pkt_cnt, 32'd5);

        // ---- 5: owner bubble while input 4 waits
        $display("[TB] scenario 5: owner bubble");
        for (int k = 0; k < 4; k++) begin
            fifo[1].push_back(mk(1, k, k == 3));
            exp_q.push_back(mk(1, k, k == 3));
        end
        exp_q.push_back(mk(4, 0, 1));
        refresh();
        tick();
        checkOutput("s5_grant1", 32'(bus.grant_o), 32'h02);
        tick();
        stall[1] = 1'b1;
        fifo[4].push_back(mk(4, 0, 1));
        refresh();
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("s5_hold", 32'(bus.grant_o), 32'h02);
            checkOutput("s5_rready", 32'(bus.r_ready_out), 32'd0);
        end
        stall = '0;
        refresh();
        wait_idle();
        check_rx("s5");
        checkOutput("s5_cnt", bus.pkt_cnt, 32'd7);

        // ---- 6: single-flit packets from all inputs rotate
        $display("[TB] scenario 6: full rotation");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) begin
                fifo[i].push_back(mk(i, r, 1));
                exp_q.push_back(mk(i, r, 1));
            end
        end
        refresh();
        for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("s6_grant", 32'(bus.grant_o), 32'd1 << (k % NP));
            checkOutput("s6_rready", 32'(bus.r_ready_out), 32'd1 << (k % NP));
            tick();
            if (k == 0) begin
                checkOutput("s6_head_lat", 32'(bus.data_o), 32'(mk(0, 0, 1)));
                checkOutput("s6_head_valid", 32'(bus.wr_ready_out), 32'd1);
            end
        end
        wait_idle();
        check_rx("s6");
        checkOutput("s6_cnt", bus.pkt_cnt, 32'd17);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
